// File: rtl/gate_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : gate_input_debouncer
//  Purpose  : Conditions raw board inputs (slide switches, push buttons)
//             before they drive the basic-gate modules. Each channel passes
//             through a 2-flop synchroniser and then a stability filter: a new
//             level must persist for STABLE_CYCLES consecutive samples before
//             it is accepted on db_out. A one-cycle rise/fall pulse marks
//             every accepted transition.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous, active-high reset
//             raw_in     - asynchronous raw input levels  [CHANNELS]
//             db_out     - debounced, registered levels   [CHANNELS]
//             rise_pulse - one-cycle pulse on db_out 0->1 [CHANNELS]
//             fall_pulse - one-cycle pulse on db_out 1->0 [CHANNELS]
//  Revision : 1.0 - initial release
// ============================================================================
module gate_input_debouncer #(
    parameter int CHANNELS      = 2,
    parameter int STABLE_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw_in,
    output logic [CHANNELS-1:0] db_out,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // Count value at which the candidate level has been seen STABLE_CYCLES
    // times (the accepting sample itself included).
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

    // Two-stage synchroniser; only the second stage feeds the filter.
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_db;
            logic             r_rise;
            logic             r_fall;
            logic             w_diff;
            logic             w_accept;

            // Any sample matching the current output restarts the count,
            // so only an unbroken run of differing samples gets through.
            assign w_diff   = r_sync2[i] ^ r_db;
            assign w_accept = w_diff && (r_cnt == c_cnt_last);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_db   <= 1'b0;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    // Pulses are registered alongside db_out, so they are
                    // high for exactly the cycle following the update.
                    r_rise <= w_accept &  r_sync2[i];
                    r_fall <= w_accept & ~r_sync2[i];
                    if (!w_diff) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_db  <= r_sync2[i];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign db_out[i]     = r_db;
            assign rise_pulse[i] = r_rise;
            assign fall_pulse[i] = r_fall;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_gate_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gate_input_debouncer
//  Purpose  : Directed self-checking bench for gate_input_debouncer with
//             CHANNELS=2, STABLE_CYCLES=4. Expected values are hand-derived.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gate_input_debouncer;

    localparam int CHANNELS      = 2;
    localparam int STABLE_CYCLES = 4;

    logic                clk;
    logic                rst;
    logic [CHANNELS-1:0] raw_in;
    logic [CHANNELS-1:0] db_out;
    logic [CHANNELS-1:0] rise_pulse;
    logic [CHANNELS-1:0] fall_pulse;

    int n_cmp;
    int n_err;

    gate_input_debouncer #(
        .CHANNELS      (CHANNELS),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pack the three outputs as {db, rise, fall} for one-shot comparison.
    function automatic logic [31:0] outs();
        return {26'd0, db_out, rise_pulse, fall_pulse};
    endfunction

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        rst    = 1'b1;
        raw_in = 2'b11;

        // Reset with inputs high: everything held at 0.
        for (int k = 0; k < 3; k++) begin
            tick();
            check("reset_hold", outs(), 32'h00);
        end

        // Release: db rises on the 6th edge after release.
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("rel_wait", outs(), 32'h00);
        end
        tick();
        check("rel_rise", outs(), {26'd0, 2'b11, 2'b11, 2'b00});
        tick();
        check("rel_pulse_end", outs(), {26'd0, 2'b11, 2'b00, 2'b00});

        // Return to all-zero state.
        rst    = 1'b1;
        raw_in = 2'b00;
        tick();
        check("reset_again", outs(), 32'h00);
        rst = 1'b0;
        tick();
        tick();

        // Bounce on ch0: alternating samples never reach db_out.
        for (int k = 0; k < 8; k++) begin
            raw_in = (k % 2 == 0) ? 2'b01 : 2'b00;
            tick();
            check("bounce", outs(), 32'h00);
        end
        raw_in = 2'b00;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("bounce_settle", outs(), 32'h00);
        end

        // Clean rise on ch0 only.
        raw_in = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("ch0_wait", outs(), 32'h00);
        end
        tick();
        check("ch0_rise", outs(), {26'd0, 2'b01, 2'b01, 2'b00});
        tick();
        check("ch0_pulse_end", outs(), {26'd0, 2'b01, 2'b00, 2'b00});

        // Glitch on ch1: high 3, low 1, then steady high.
        raw_in = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("glitch_hi", outs(), {26'd0, 2'b01, 2'b00, 2'b00});
        end
        raw_in = 2'b01;
        tick();
        check("glitch_lo", outs(), {26'd0, 2'b01, 2'b00, 2'b00});
        raw_in = 2'b11;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("glitch_wait", outs(), {26'd0, 2'b01, 2'b00, 2'b00});
        end
        tick();
        check("glitch_rise", outs(), {26'd0, 2'b11, 2'b10, 2'b00});
        tick();
        check("glitch_pulse_end", outs(), {26'd0, 2'b11, 2'b00, 2'b00});

        // Simultaneous fall on both channels.
        raw_in = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("fall_wait", outs(), {26'd0, 2'b11, 2'b00, 2'b00});
        end
        tick();
        check("fall_both", outs(), {26'd0, 2'b00, 2'b00, 2'b11});
        tick();
        check("fall_pulse_end", outs(), 32'h00);

        // Reset in the middle of a count on ch0.
        raw_in = 2'b01;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("mid_count", outs(), 32'h00);
        end
        rst = 1'b1;
        tick();
        check("mid_reset", outs(), 32'h00);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("post_reset_wait", outs(), 32'h00);
        end
        tick();
        check("post_reset_rise", outs(), {26'd0, 2'b01, 2'b01, 2'b00});
        tick();
        check("post_reset_end", outs(), {26'd0, 2'b01, 2'b00, 2'b00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gate_input_debouncer.md
Name: gate_input_debouncer

Overview:
- Conditions raw board inputs (slide switches, push buttons) before they drive the basic-gate modules.
- Each channel is synchronised to the clock with a 2-flop synchroniser, then filtered so that only levels held stable for STABLE_CYCLES samples reach the output.
- Each channel also produces one-cycle rise/fall pulses for downstream counters and monitors.
- Sits directly upstream of the gate under test; its debounced outputs connect to the gate's a/b inputs.

Parameters:
- CHANNELS, 2, number of independent input channels (>=1).
- STABLE_CYCLES, 1000, consecutive clock samples a new level must persist before it is accepted (>=2). Sim benches use 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- raw_in  input  CHANNELS  asynchronous raw input levels.
- db_out  output  CHANNELS  debounced, registered levels (gate inputs).
- rise_pulse  output  CHANNELS  one-cycle high when db_out[i] goes 0->1.
- fall_pulse  output  CHANNELS  one-cycle high when db_out[i] goes 1->0.

Behaviour:
- One clock; reset is synchronous and active-high.
- While rst is sampled high, the following all clear to 0 at the clock edge: the sync flops (s1, s2), db_out, rise_pulse, fall_pulse, and every counter. raw_in is ignored during reset.
- Synchroniser: s1 <= raw_in; s2 <= s1. Only s2 feeds the filter. raw_in is never used combinationally.
- Per-channel counter: width $clog2(STABLE_CYCLES+1), unsigned. The following are evaluated per edge with rst low:
  - s2[i] == db_out[i]: cnt[i] <= 0.
  - s2[i] != db_out[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s2[i] != db_out[i] and cnt[i] == STABLE_CYCLES-1: db_out[i] <= s2[i]; cnt[i] <= 0; the matching pulse goes high.
- Counter never exceeds STABLE_CYCLES-1; no wrap-around is possible.
- Latency: raw_in held stable from before edge k is captured in s2 at edge k+1; db_out changes at edge k+1+STABLE_CYCLES.
- Glitch rejection: a single sample of s2 equal to db_out restarts the count from 0. A bounce shorter than STABLE_CYCLES samples never reaches db_out.
- Pulses are registered:
  - Asserted after the same edge that updates db_out, deasserted at the next edge.
  - Exactly one cycle wide.
  - rise_pulse and fall_pulse are never high together on the same channel.
- Channels are fully independent; simultaneous transitions on several channels are filtered in parallel with no interaction.
- Reset mid-count: count is discarded and db_out returns to 0. If raw_in is high at reset release, db_out rises STABLE_CYCLES+2 edges after the first post-reset edge, with one rise_pulse.
- No state machine beyond the per-channel counter/compare. No X propagation from raw_in after reset (two sync stages tolerate metastability).

Test Plan:
- Reset check: rst=1 for 3 cycles with raw_in=2'b11 -> db_out=0, rise_pulse=0, fall_pulse=0 throughout. Release rst, hold raw_in -> db_out=2'b11 after 6 edges (STABLE_CYCLES=4), rise_pulse=2'b11 for exactly 1 cycle.
- Clean rise on ch0: raw_in[0] 0->1 before edge 0 -> db_out[0]=1 after edge 5, rise_pulse[0] high cycle 5 only; ch1 unchanged.
- Bounce rejection: raw_in[0] toggled 1,0,1,0 each cycle for 8 cycles, then held 0 -> db_out[0] stays 0, no pulses.
- Glitch restart: raw_in[1] high for 3 cycles, low 1 cycle, high steady -> db_out[1] rises 6 edges after the final rising edge of raw_in[1], not earlier.
- Fall and simultaneous channels: both db_out=1, raw_in 2'b11->2'b00 at once -> both fall_pulse bits high in the same cycle, db_out=2'b00, no rise_pulse.
- Reset mid-count: raw_in[0]=1, assert rst at count 2 for 1 cycle -> db_out[0]=0, cnt cleared. After release, rise occurs 6 edges later.
